// File: rtl/logic_basic_queue_pkg.sv
// -----------------------------------------------------------------------------
// logic_basic_queue_pkg
// Shared definitions for the generic queue's write-side controller.
//   logic_basic_queue_write_state_t : packet-mode write FSM states
//   pointer_width()                 : pointer width (address bits + wrap bit)
// -----------------------------------------------------------------------------
package logic_basic_queue_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,  // between packets, nothing uncommitted
        IN_PACKET = 2'd1,  // at least one beat of the current packet written
        DISCARD   = 2'd2   // oversize packet: swallow beats until tlast
    } logic_basic_queue_write_state_t;

    // Pointers carry one extra MSB so that full (wrap bits differ) and
    // empty (wrap bits equal) are distinguishable with equal address bits.
    function automatic int pointer_width(input int address_width);
        return address_width + 1;
    endfunction

endpackage

// File: rtl/logic_basic_queue_packet_write_if.sv
// -----------------------------------------------------------------------------
// logic_basic_queue_packet_write_if
// AXI4-Stream receive channel into the queue write controller.
//   tvalid : beat valid                 (master -> slave)
//   tdata  : beat data, DATA_WIDTH bits (master -> slave)
//   tlast  : last beat of a packet      (master -> slave)
//   tuser  : drop request on last beat  (master -> slave)
//   tready : beat ready                 (slave  -> master)
// DATA_WIDTH must match the DATA_WIDTH of the controller it is bound to.
// -----------------------------------------------------------------------------
interface logic_basic_queue_packet_write_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tuser;
    logic                  tready;

    modport master (
        output tvalid, tdata, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/logic_basic_queue_packet_write.sv
// -----------------------------------------------------------------------------
// logic_basic_queue_packet_write
// Write-side controller of the generic queue. Accepts AXI4-Stream beats,
// drives the RAM write port and publishes a commit pointer to the reader.
// With PACKET_MODE=1 a packet only becomes visible once its last beat is
// accepted; packets flagged by tuser, or longer than the queue, are rolled
// back and never become visible.
//
// Parameters
//   DATA_WIDTH    : beat / RAM data width
//   ADDRESS_WIDTH : RAM address width, DEPTH = 2**ADDRESS_WIDTH
//   PACKET_MODE   : 0 = commit every beat, 1 = commit on tlast
// Ports
//   aclk, areset_n : clock, asynchronous active-low reset
//   rx             : AXI4-Stream slave (tready is registered)
//   write_enable   : RAM write strobe (combinational)
//   write_address  : RAM write address
//   write_data     : RAM write data
//   read_pointer   : reader's pointer, including wrap bit
//   commit_pointer : end of committed data (exclusive), including wrap bit
//   packet_dropped : one-cycle pulse when a packet is rolled back
// -----------------------------------------------------------------------------
module logic_basic_queue_packet_write
    import logic_basic_queue_pkg::*;
#(
    parameter int DATA_WIDTH    = 1,
    parameter int ADDRESS_WIDTH = 1,
    parameter int PACKET_MODE   = 0,
    localparam int POINTER_WIDTH = pointer_width(ADDRESS_WIDTH)
) (
    input  logic                               aclk,
    input  logic                               areset_n,
    logic_basic_queue_packet_write_if.slave    rx,
    output logic                               write_enable,
    output logic [ADDRESS_WIDTH-1:0]           write_address,
    output logic [DATA_WIDTH-1:0]              write_data,
    input  logic [POINTER_WIDTH-1:0]           read_pointer,
    output logic [POINTER_WIDTH-1:0]           commit_pointer,
    output logic                               packet_dropped
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [POINTER_WIDTH-1:0] DEPTH_LEVEL       = POINTER_WIDTH'(DEPTH);
    localparam logic [POINTER_WIDTH-1:0] ALMOST_FULL_LEVEL = POINTER_WIDTH'(DEPTH - 1);
    localparam logic [POINTER_WIDTH-1:0] POINTER_ONE       = POINTER_WIDTH'(1);

    logic_basic_queue_write_state_t state;
    logic_basic_queue_write_state_t state_next;

    logic [POINTER_WIDTH-1:0] wp;
    logic [POINTER_WIDTH-1:0] wp_next;
    logic [POINTER_WIDTH-1:0] wp_inc;
    logic [POINTER_WIDTH-1:0] commit_next;
    logic [POINTER_WIDTH-1:0] used;

    logic accept;
    logic almost_full;
    logic tready_next;
    logic dropped_next;

    // ------------------------------------------------------------------
    // Data path: zero latency, the RAM write happens in the accept cycle.
    // Beats swallowed in DISCARD are not written at all.
    // ------------------------------------------------------------------
    assign accept        = rx.tvalid && rx.tready;
    assign write_enable  = accept && (state != DISCARD);
    assign write_address = wp[ADDRESS_WIDTH-1:0];
    assign write_data    = rx.tdata;

    // Pointer arithmetic wraps modulo 2**POINTER_WIDTH by construction.
    assign wp_inc      = wp + POINTER_ONE;
    assign used        = wp - read_pointer;
    // Ready is registered, so one more beat can slip in after this goes
    // high; stopping at DEPTH-1 leaves exactly that one slot spare.
    assign almost_full = (used >= ALMOST_FULL_LEVEL);

    // ------------------------------------------------------------------
    // Next-state / next-pointer logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; a missed assignment would infer a latch.
        state_next   = state;
        wp_next      = wp;
        commit_next  = commit_pointer;
        dropped_next = 1'b0;

        if (PACKET_MODE == 0) begin
            // Streaming: every accepted beat is visible on the next cycle.
            if (accept) begin
                wp_next     = wp_inc;
                commit_next = wp_inc;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (rx.tlast) begin
                            // Single-beat packet. A dropped one was written
                            // to RAM but wp stays put, so it is overwritten.
                            if (rx.tuser) begin
                                dropped_next = 1'b1;
                            end else begin
                                wp_next     = wp_inc;
                                commit_next = wp_inc;
                            end
                        end else begin
                            wp_next    = wp_inc;
                            state_next = IN_PACKET;
                        end
                    end
                end

                IN_PACKET: begin
                    if (accept) begin
                        if (rx.tlast) begin
                            if (rx.tuser) begin
                                wp_next      = commit_pointer;
                                dropped_next = 1'b1;
                            end else begin
                                wp_next     = wp_inc;
                                commit_next = wp_inc;
                            end
                            state_next = IDLE;
                        end else if ((wp_inc - commit_pointer) == DEPTH_LEVEL) begin
                            // The packet has filled the whole queue without
                            // ending; it can never be committed, so roll it
                            // back now and swallow the rest.
                            wp_next    = commit_pointer;
                            state_next = DISCARD;
                        end else begin
                            wp_next = wp_inc;
                        end
                    end
                end

                DISCARD: begin
                    if (accept && rx.tlast) begin
                        dropped_next = 1'b1;
                        state_next   = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // DISCARD never writes, so it may accept regardless of fill level.
        tready_next = (state_next == DISCARD) ? 1'b1 : !almost_full;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments make every register here sample the
    // pre-edge values, so the order of the statements does not matter.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state          <= IDLE;
            wp             <= '0;
            commit_pointer <= '0;
            rx.tready      <= 1'b0;
            packet_dropped <= 1'b0;
        end else begin
            state          <= state_next;
            wp             <= wp_next;
            commit_pointer <= commit_next;
            rx.tready      <= tready_next;
            packet_dropped <= dropped_next;
        end
    end

endmodule
